// File: rtl/pc_sequencer.sv
// Purpose: RV32I fetch-address sequencer with redirect, stall and misaligned-target trap.
// Latency: pc, pc_valid, trap, trap_addr and fetch_count are registered (1 cycle); pc_plus_step is combinational.
// Backpressure: pc holds while stall=1 or fetch_ready=0; a redirect overrides stall.
module pc_sequencer #(
    parameter int unsigned           XLEN         = 32,
    parameter logic [XLEN-1:0]       RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0]       TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned           IALIGN       = 32,
    parameter int unsigned           CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             fetch_ready,
    output logic [XLEN-1:0]  pc,
    output logic             pc_valid,
    output logic [XLEN-1:0]  pc_plus_step,
    output logic             trap,
    output logic [XLEN-1:0]  trap_addr,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_e;

    localparam logic [XLEN-1:0]  STEP_V  = XLEN'(IALIGN / 8);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              pc_valid_q, pc_valid_d;
    logic              trap_q, trap_d;
    logic [XLEN-1:0]   trap_addr_q, trap_addr_d;
    logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;

    logic              target_misaligned;
    logic              fetch_accept;
    logic [XLEN-1:0]   pc_next_seq;

    // 16-bit alignment only needs bit 0 clear (compressed ISA); 32-bit needs both low bits clear.
    assign target_misaligned = (IALIGN == 16) ? redirect_target[0]
                                              : (redirect_target[1:0] != 2'b00);

    assign pc_next_seq  = pc_q + STEP_V;
    assign fetch_accept = (state_q == ST_RUN) && fetch_ready && !stall && !redirect_valid;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_valid_d    = pc_valid_q;
        trap_d        = 1'b0;
        trap_addr_d   = trap_addr_q;
        fetch_count_d = fetch_count_q;

        unique case (state_q)
            ST_BOOT: begin
                state_d    = ST_RUN;
                pc_valid_d = 1'b1;
            end
            ST_RUN: begin
                pc_valid_d = 1'b1;
                if (redirect_valid) begin
                    if (target_misaligned) begin
                        state_d     = ST_TRAP;
                        pc_d        = TRAP_VECTOR;
                        pc_valid_d  = 1'b0;
                        trap_d      = 1'b1;
                        trap_addr_d = redirect_target;
                    end else begin
                        pc_d = redirect_target;
                    end
                end else if (fetch_accept) begin
                    pc_d = pc_next_seq;
                    if (fetch_count_q != CNT_MAX) begin
                        fetch_count_d = fetch_count_q + CNT_W'(1);
                    end
                end
            end
            ST_TRAP: begin
                // pc already holds TRAP_VECTOR; resume fetching from there.
                state_d    = ST_RUN;
                pc_valid_d = 1'b1;
            end
            default: begin
                state_d    = ST_BOOT;
                pc_d       = RESET_VECTOR;
                pc_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_VECTOR;
            pc_valid_q    <= 1'b0;
            trap_q        <= 1'b0;
            trap_addr_q   <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_valid_q    <= pc_valid_d;
            trap_q        <= trap_d;
            trap_addr_q   <= trap_addr_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pc           = pc_q;
    assign pc_valid     = pc_valid_q;
    assign pc_plus_step = pc_next_seq;
    assign trap         = trap_q;
    assign trap_addr    = trap_addr_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: three configurations (default, IALIGN=16, CNT_W=4) driven in lockstep
// and compared every cycle against an arithmetic reference model, plus directed spot checks.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        fetch_ready = 1'b0;

    logic [31:0] pc0, pps0, ta0;  logic vld0, trap0;  logic [31:0] fc0;
    logic [31:0] pc1, pps1, ta1;  logic vld1, trap1;  logic [31:0] fc1;
    logic [31:0] pc2, pps2, ta2;  logic vld2, trap2;  logic [3:0]  fc2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_sequencer dut0 (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .fetch_ready(fetch_ready),
        .pc(pc0), .pc_valid(vld0), .pc_plus_step(pps0), .trap(trap0),
        .trap_addr(ta0), .fetch_count(fc0)
    );

    pc_sequencer #(.IALIGN(16)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .fetch_ready(fetch_ready),
        .pc(pc1), .pc_valid(vld1), .pc_plus_step(pps1), .trap(trap1),
        .trap_addr(ta1), .fetch_count(fc1)
    );

    pc_sequencer #(.CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .fetch_ready(fetch_ready),
        .pc(pc2), .pc_valid(vld2), .pc_plus_step(pps2), .trap(trap2),
        .trap_addr(ta2), .fetch_count(fc2)
    );

    // Reference model: per configuration, the observable state only.
    longint unsigned m_pc[3];
    bit              m_vld[3];
    bit              m_trap[3];
    longint unsigned m_taddr[3];
    longint unsigned m_cnt[3];
    longint unsigned step_bytes[3] = '{4, 2, 4};
    longint unsigned cnt_max[3]    = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hF};

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_pc[i] = 0; m_vld[i] = 0; m_trap[i] = 0; m_taddr[i] = 0; m_cnt[i] = 0;
        end
    endtask

    // One clock edge: not-yet-valid (boot or trap cycle) always resolves to fetching, pc kept.
    task automatic model_edge(input bit st, input bit rv, input longint unsigned tgt, input bit fr);
        for (int i = 0; i < 3; i++) begin
            if (!m_vld[i]) begin
                m_vld[i] = 1; m_trap[i] = 0;
            end else if (rv) begin
                if (tgt % step_bytes[i] != 0) begin
                    m_pc[i] = 64'h100; m_taddr[i] = tgt; m_vld[i] = 0; m_trap[i] = 1;
                end else begin
                    m_pc[i] = tgt;
                end
            end else if (!st && fr) begin
                m_pc[i] = (m_pc[i] + step_bytes[i]) % 64'h1_0000_0000;
                if (m_cnt[i] < cnt_max[i]) m_cnt[i] = m_cnt[i] + 1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] plus_step(input int i);
        return (m_pc[i] + step_bytes[i]) % 64'h1_0000_0000;
    endfunction

    task automatic check_all();
        check("d0_pc",   {32'h0, pc0},  m_pc[0]);
        check("d0_vld",  {63'h0, vld0}, {63'h0, m_vld[0]});
        check("d0_pps",  {32'h0, pps0}, plus_step(0));
        check("d0_trap", {63'h0, trap0}, {63'h0, m_trap[0]});
        check("d0_ta",   {32'h0, ta0},  m_taddr[0]);
        check("d0_cnt",  {32'h0, fc0},  m_cnt[0]);
        check("d1_pc",   {32'h0, pc1},  m_pc[1]);
        check("d1_vld",  {63'h0, vld1}, {63'h0, m_vld[1]});
        check("d1_pps",  {32'h0, pps1}, plus_step(1));
        check("d1_trap", {63'h0, trap1}, {63'h0, m_trap[1]});
        check("d1_ta",   {32'h0, ta1},  m_taddr[1]);
        check("d1_cnt",  {32'h0, fc1},  m_cnt[1]);
        check("d2_pc",   {32'h0, pc2},  m_pc[2]);
        check("d2_vld",  {63'h0, vld2}, {63'h0, m_vld[2]});
        check("d2_pps",  {32'h0, pps2}, plus_step(2));
        check("d2_trap", {63'h0, trap2}, {63'h0, m_trap[2]});
        check("d2_ta",   {32'h0, ta2},  m_taddr[2]);
        check("d2_cnt",  {60'h0, fc2},  m_cnt[2]);
    endtask

    // Drive inputs just after an edge, let the next edge take them, then compare.
    task automatic step(input bit st, input bit rv, input logic [31:0] tgt, input bit fr);
        stall = st; redirect_valid = rv; redirect_target = tgt; fetch_ready = fr;
        @(posedge clk);
        if (rst) model_edge(st, rv, {32'h0, tgt}, fr);
        #1;
        check_all();
    endtask

    task automatic async_reset_pulse();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_all();
    endtask

    logic [31:0] tgt;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b1;
        check("boot_vld", {63'h0, vld0}, 64'h0);
        check("boot_pc", {32'h0, pc0}, 64'h0);

        // Boot into RUN, then 32 sequential fetches.
        step(0, 0, 0, 1);
        check("run_vld", {63'h0, vld0}, 64'h1);
        check("run_pc0", {32'h0, pc0}, 64'h0);
        for (int i = 0; i < 32; i++) step(0, 0, 0, 1);
        check("seq_cnt32", {32'h0, fc0}, 64'd32);
        check("seq_pc", {32'h0, pc0}, 64'h80);

        // Stall and backpressure at 0x10.
        step(0, 1, 32'h10, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0);
        check("hold_pc", {32'h0, pc0}, 64'h10);
        check("hold_cnt", {32'h0, fc0}, 64'd32);
        step(0, 0, 0, 1);
        check("release_pc", {32'h0, pc0}, 64'h14);

        // Redirect beats stall.
        step(0, 1, 32'h20, 0);
        step(1, 1, 32'h400, 1);
        check("redir_pc", {32'h0, pc0}, 64'h400);
        check("redir_cnt", {32'h0, fc0}, 64'd33);
        step(0, 0, 0, 1);
        check("redir_next", {32'h0, pc0}, 64'h404);

        // Misaligned redirect: traps at 32-bit alignment, legal at 16-bit.
        step(0, 1, 32'h402, 0);
        check("trap_pulse", {63'h0, trap0}, 64'h1);
        check("trap_vld", {63'h0, vld0}, 64'h0);
        check("trap_pc", {32'h0, pc0}, 64'h100);
        check("trap_addr", {32'h0, ta0}, 64'h402);
        check("ialign16_legal", {32'h0, pc1}, 64'h402);
        step(0, 1, 32'h800, 1);
        check("trap_end", {63'h0, trap0}, 64'h0);
        check("trap_resume_vld", {63'h0, vld0}, 64'h1);
        check("trap_resume_pc", {32'h0, pc0}, 64'h100);
        step(0, 1, 32'h401, 0);
        check("ialign16_trap", {63'h0, trap1}, 64'h1);
        check("ialign16_ta", {32'h0, ta1}, 64'h401);
        step(0, 0, 0, 0);

        // Wrap and saturation.
        step(0, 1, 32'hFFFF_FFFC, 0);
        check("wrap_pps", {32'h0, pps0}, 64'h0);
        step(0, 0, 0, 1);
        check("wrap_pc", {32'h0, pc0}, 64'h0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
        check("sat_cnt4", {60'h0, fc2}, 64'hF);

        // Asynchronous reset between edges.
        step(0, 1, 32'h48, 0);
        check("pre_rst_pc", {32'h0, pc0}, 64'h48);
        #2;
        rst = 1'b0;
        #1;
        check("arst_pc", {32'h0, pc0}, 64'h0);
        check("arst_vld", {63'h0, vld0}, 64'h0);
        check("arst_cnt", {32'h0, fc0}, 64'h0);
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset_pulse();
            end else begin
                case ($urandom_range(0, 3))
                    0: tgt = $urandom;
                    1: tgt = $urandom & 32'hFFFF_FFFC;
                    2: tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                    default: tgt = 32'($urandom_range(0, 255));
                endcase
                step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, tgt,
                     $urandom_range(0, 3) != 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
